// File: rtl/cpu_run_ctrl_if.sv
// rtl/cpu_run_ctrl_if.sv - run/debug control bundle between requester, sequencer and CPU
//
// Purpose: groups the run-control requests, breakpoint/done/budget settings,
// CPU observation signals and the sequencer outputs into one bundle.
// Ports (signals):
//   start, step, halt_req, restart   run-control requests (levels)
//   bp_en, bp_addr                   PC breakpoint
//   done_en, done_val                x31 completion check
//   max_cycles                       cycle budget, 0 = unlimited
//   pc, x31                          observed from the CPU
//   cpu_rst, cpu_en                  CPU reset and clock-enable
//   state, halted, halt_cause        sequencer status
//   cycle_count                      cycles executed since last RESET_HOLD
// Modports: master drives requests and CPU observations, slave is the sequencer.
interface cpu_run_ctrl_if #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 32
);
   logic             start;
   logic             step;
   logic             halt_req;
   logic             restart;
   logic             bp_en;
   logic [XLEN-1:0]  bp_addr;
   logic             done_en;
   logic [XLEN-1:0]  done_val;
   logic [CNT_W-1:0] max_cycles;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  x31;
   logic             cpu_rst;
   logic             cpu_en;
   logic [2:0]       state;
   logic             halted;
   logic [2:0]       halt_cause;
   logic [CNT_W-1:0] cycle_count;

   modport master (
      output start, step, halt_req, restart, bp_en, bp_addr,
             done_en, done_val, max_cycles, pc, x31,
      input  cpu_rst, cpu_en, state, halted, halt_cause, cycle_count
   );

   modport slave (
      input  start, step, halt_req, restart, bp_en, bp_addr,
             done_en, done_val, max_cycles, pc, x31,
      output cpu_rst, cpu_en, state, halted, halt_cause, cycle_count
   );
endinterface

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/debug sequencer owning CPU reset, clock-enable and cycle count
//
// Purpose: holds the CPU in reset for RST_CYCLES cycles, then starts,
// single-steps, resumes and halts it on external request, PC breakpoint,
// x31 done value or cycle-budget timeout.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-high reset of this block
//   bus    slave modport of cpu_run_ctrl_if (requests, CPU observation, status)
module cpu_run_ctrl #(
   parameter int XLEN       = 32,
   parameter int RST_CYCLES = 3,
   parameter int CNT_W      = 32
) (
   input  logic           clk,
   input  logic           reset,
   cpu_run_ctrl_if.slave  bus
);

   localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   typedef enum logic [2:0] {
      S_RESET_HOLD = 3'd0,
      S_IDLE       = 3'd1,
      S_RUN        = 3'd2,
      S_STEP       = 3'd3,
      S_HALTED     = 3'd4
   } state_t;

   localparam logic [2:0] C_NONE    = 3'd0;
   localparam logic [2:0] C_HALTREQ = 3'd1;
   localparam logic [2:0] C_BP      = 3'd2;
   localparam logic [2:0] C_DONE    = 3'd3;
   localparam logic [2:0] C_TIMEOUT = 3'd4;
   localparam logic [2:0] C_STEP    = 3'd5;

   state_t             state_q, state_d;
   logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
   logic               resume_q, resume_d;
   logic [2:0]         halt_cause_q, halt_cause_d;
   logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;

   logic               cpu_rst;
   logic               cpu_en;
   logic               clear_count;
   logic               timeout;
   logic               bp_hit;
   logic               done_hit;
   logic [2:0]         run_cause;
   logic [XLEN-1:0]    pc;

   assign pc = bus.pc;

   // Halt sources evaluated on the current cycle's inputs; priority order
   // decides the reported cause when several fire together.
   always_comb begin
      timeout  = (bus.max_cycles != '0) && (cycle_count_q >= bus.max_cycles);
      bp_hit   = bus.bp_en && (pc == bus.bp_addr) && !resume_q;
      done_hit = bus.done_en && (bus.x31 == bus.done_val);
      run_cause = C_NONE;
      if (bus.halt_req)  run_cause = C_HALTREQ;
      else if (bp_hit)   run_cause = C_BP;
      else if (done_hit) run_cause = C_DONE;
      else if (timeout)  run_cause = C_TIMEOUT;
   end

   always_comb begin
      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      resume_d     = resume_q;
      halt_cause_d = halt_cause_q;
      cpu_rst      = 1'b0;
      cpu_en       = 1'b0;
      clear_count  = 1'b0;

      case (state_q)
         S_RESET_HOLD: begin
            cpu_rst = 1'b1;
            if (hold_cnt_q == HOLD_W'(RST_CYCLES - 1)) begin
               state_d    = S_IDLE;
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
         end
         S_IDLE: begin
            if (bus.start) begin
               state_d      = S_RUN;
               resume_d     = 1'b0;
               halt_cause_d = C_NONE;
            end else if (bus.step) begin
               state_d      = S_STEP;
               halt_cause_d = C_NONE;
            end
         end
         S_RUN: begin
            // The halting instruction is held back, so a breakpoint stops
            // before the instruction at bp_addr executes.
            resume_d = 1'b0;
            if (run_cause != C_NONE) begin
               state_d      = S_HALTED;
               halt_cause_d = run_cause;
            end else begin
               cpu_en = 1'b1;
            end
         end
         S_STEP: begin
            state_d = S_HALTED;
            if (timeout) begin
               halt_cause_d = C_TIMEOUT;
            end else begin
               cpu_en       = 1'b1;
               halt_cause_d = C_STEP;
            end
         end
         S_HALTED: begin
            if (bus.restart) begin
               state_d      = S_RESET_HOLD;
               hold_cnt_d   = '0;
               resume_d     = 1'b0;
               halt_cause_d = C_NONE;
               clear_count  = 1'b1;
            end else if (bus.start) begin
               // Skip the breakpoint at the current pc once so resume makes progress.
               state_d      = S_RUN;
               resume_d     = 1'b1;
               halt_cause_d = C_NONE;
            end else if (bus.step) begin
               state_d      = S_STEP;
               halt_cause_d = C_NONE;
            end
         end
         default: begin
            state_d    = S_RESET_HOLD;
            hold_cnt_d = '0;
         end
      endcase

      if (cpu_rst) cpu_en = 1'b0;

      cycle_count_d = cycle_count_q;
      if (clear_count) begin
         cycle_count_d = '0;
      end else if (cpu_en && (cycle_count_q != '1)) begin
         cycle_count_d = cycle_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_RESET_HOLD;
         hold_cnt_q    <= '0;
         resume_q      <= 1'b0;
         halt_cause_q  <= C_NONE;
         cycle_count_q <= '0;
      end else begin
         state_q       <= state_d;
         hold_cnt_q    <= hold_cnt_d;
         resume_q      <= resume_d;
         halt_cause_q  <= halt_cause_d;
         cycle_count_q <= cycle_count_d;
      end
   end

   assign bus.cpu_rst     = cpu_rst;
   assign bus.cpu_en      = cpu_en;
   assign bus.state       = state_q;
   assign bus.halted      = (state_q == S_HALTED);
   assign bus.halt_cause  = halt_cause_q;
   assign bus.cycle_count = cycle_count_q;

endmodule
